// File: rtl/md_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU op codes.
package md_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_MUL,
    CLS_DIV,
    CLS_MOVE
  } md_class_e;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;
  localparam int unsigned CNT_W       = 4;

  // Undefined codes (and MADD-class when disabled) fall into CLS_NONE.
  function automatic md_class_e op_class(input logic [3:0] op);
    md_class_e cls;
    cls = CLS_NONE;
    case (op)
      OP_MULT, OP_MULTU: cls = CLS_MUL;
      OP_DIV, OP_DIVU:   cls = CLS_DIV;
      OP_MTHI, OP_MTLO:  cls = CLS_MOVE;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = CLS_MUL;
`endif
      default:           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generation for multiply, divide and (with
// MDU_MADD_EN) multiply-accumulate. Result packs {hi, lo}.
module mdu_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        div_zero;
  logic        div_ovf;

  always_comb begin
    prod_s   = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u   = {32'b0, rs_val} * {32'b0, rt_val};
    div_zero = (rt_val == '0);
    div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == '1);

    quo_u = div_zero ? '1     : rs_val / rt_val;
    rem_u = div_zero ? rs_val : rs_val % rt_val;

    // Signed divide via magnitudes: quotient sign is the XOR of the operand
    // signs, remainder follows the dividend.
    a_mag = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    b_mag = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    q_mag = div_zero ? '0 : a_mag / b_mag;
    r_mag = div_zero ? '0 : a_mag % b_mag;
    quo_s = (rs_val[31] ^ rt_val[31]) ? (~q_mag + 32'd1) : q_mag;
    rem_s = rs_val[31] ? (~r_mag + 32'd1) : r_mag;
    if (div_zero) begin
      quo_s = '1;
      rem_s = rs_val;
    end else if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = '0;
    end

    result = {hi, lo};
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = {rem_s, quo_s};
      OP_DIVU:  result = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi, lo} + prod_s;
      OP_MADDU: result = {hi, lo} + prod_u;
      OP_MSUB:  result = {hi, lo} - prod_s;
      OP_MSUBU: result = {hi, lo} - prod_u;
`endif
      default:  result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with the HI/LO register pair.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_hilo
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        ex_cancel,
  output logic        md_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      pending_q;
  logic [63:0]      calc_res;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             busy_q;
  logic             accept;
  md_class_e        op_cls;

  mdu_calc u_calc (
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (calc_res)
  );

  always_comb begin
    op_cls = op_class(op);
    accept = start && !ex_cancel && (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (op_cls == CLS_MUL || op_cls == CLS_DIV)) state_d = RUN;
      RUN:  if (ex_cancel || cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_q  = (state_q == RUN);
    md_busy = start | busy_q;
    hi      = hi_q;
    lo      = lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        case (op_cls)
          CLS_MUL: begin
            pending_q <= calc_res;
            cnt_q     <= MUL_CNT;
          end
          CLS_DIV: begin
            pending_q <= calc_res;
            cnt_q     <= DIV_CNT;
          end
          CLS_MOVE: begin
            if (op == OP_MTHI) hi_q <= rs_val;
            else               lo_q <= rs_val;
          end
          default: ;
        endcase
      end
    end else if (ex_cancel) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) {hi_q, lo_q} <= pending_q;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: driver pushes expected {hi,lo,busy length},
// monitor pops on each falling edge of md_busy.
module tb_mdu_hilo;
  import md_pkg::*;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ex_cancel = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        md_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mdu_hilo #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .ex_cancel (ex_cancel),
    .md_busy   (md_busy),
    .hi        (hi),
    .lo        (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          run_len = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Architectural reference: 64-bit integer arithmetic on the operands.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l,
                                output logic [31:0] nh, output logic [31:0] nl, output int len);
    longint      sa, sbv, q, r;
    logic [63:0] acc, p;
    nh = h; nl = l; len = 1;
    sa = longint'(int'(a));
    sbv = longint'(int'(b));
    acc = {h, l};
    case (o)
      4'd0: begin p = 64'(sa * sbv); {nh, nl} = p; len = int'(MUL_LAT) + 1; end
      4'd1: begin p = {32'b0, a} * {32'b0, b}; {nh, nl} = p; len = int'(MUL_LAT) + 1; end
      4'd2, 4'd3: begin
        len = int'(DIV_LAT) + 1;
        if (b == 0) begin nh = a; nl = '1; end
        else if (o == 4'd2) begin q = sa / sbv; r = sa % sbv; nl = q[31:0]; nh = r[31:0]; end
        else begin nl = a / b; nh = a % b; end
      end
      4'd4: nh = a;
      4'd5: nl = a;
`ifdef MDU_MADD_EN
      4'd6: begin {nh, nl} = acc + 64'(sa * sbv); len = int'(MUL_LAT) + 1; end
      4'd7: begin {nh, nl} = acc + {32'b0, a} * {32'b0, b}; len = int'(MUL_LAT) + 1; end
      4'd8: begin {nh, nl} = acc - 64'(sa * sbv); len = int'(MUL_LAT) + 1; end
      4'd9: begin {nh, nl} = acc - {32'b0, a} * {32'b0, b}; len = int'(MUL_LAT) + 1; end
`endif
      default: ;
    endcase
  endfunction

  always @(posedge clk)
    if (rst_n) assert (!(start && dut.busy_q)) else $error("start issued while unit running");

  always @(negedge clk) begin
    exp_t e;
    if (md_busy === 1'b1) begin
      run_len++;
      if (run_len == 64) begin
        checks++; failures++;
        $display("FAIL busy_stuck: md_busy high %0d cycles, required at most %0d", run_len, DIV_LAT + 1);
      end
    end else if (run_len > 0) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_busy: busy run of %0d cycles, required none", run_len);
      end else begin
        e = exp_q.pop_front();
        check32({e.tag, "_hi"}, hi, e.hi);
        check32({e.tag, "_lo"}, lo, e.lo);
        check32({e.tag, "_busy_len"}, 32'(run_len), 32'(e.len));
      end
      run_len = 0;
    end
  end

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (md_busy !== 1'b0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 64) begin
      checks++; failures++;
      $display("FAIL wait_idle: md_busy %b after %0d cycles, required 0", md_busy, n);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
    end
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int len, input string tag);
    exp_t e;
    e = '{hi: h, lo: l, len: len, tag: tag};
    exp_q.push_back(e);
    m_hi = h;
    m_lo = l;
  endtask

  task automatic drive_start(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit cancel);
    op = o; rs_val = a; rt_val = b; start = 1'b1; ex_cancel = cancel;
    @(posedge clk); #1;
    start = 1'b0; ex_cancel = 1'b0;
    op = 4'($urandom); rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit cancel, input string tag);
    logic [31:0] nh, nl;
    int len;
    wait_idle();
    if (cancel) begin nh = m_hi; nl = m_lo; len = 1; end
    else model(o, a, b, m_hi, m_lo, nh, nl, len);
    push(nh, nl, len, tag);
    drive_start(o, a, b, cancel);
  endtask

  task automatic mt_pair(input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    push(a, b, 2, "mt_pair");
    op = 4'd4; rs_val = a; start = 1'b1;
    @(posedge clk); #1;
    check32("mthi_visible", hi, a);
    op = 4'd5; rs_val = b;
    @(posedge clk); #1;
    check32("mtlo_visible", lo, b);
    start = 1'b0;
  endtask

  task automatic cancel_run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int at);
    wait_idle();
    push(m_hi, m_lo, at + 1, "cancel");
    drive_start(o, a, b, 1'b0);
    repeat (at - 1) begin @(posedge clk); #1; end
    ex_cancel = 1'b1;
    @(posedge clk); #1;
    ex_cancel = 1'b0;
    check32("cancel_idle", 32'(md_busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check32("reset_hi", hi, '0);
    check32("reset_lo", lo, '0);
    check32("reset_busy", 32'(md_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg");
    issue(4'd3, 32'd100, 32'd7, 1'b0, "divu_100_7");
    issue(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    issue(4'd3, 32'd5, 32'd0, 1'b0, "divu_zero");
    issue(4'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, "div_zero");
    mt_pair(32'h1234_5678, 32'h9);
    cancel_run(4'd1, 32'hFFFF_FFFF, 32'd2, 3);
    issue(4'd0, 32'd7, 32'd9, 1'b1, "start_cancel");
    issue(4'd4, 32'hDEAD_BEEF, 32'd0, 1'b1, "mthi_cancel");
    issue(4'd12, 32'd1, 32'd1, 1'b0, "undef_op");

    mt_pair(32'd0, 32'd10);
    issue(4'd6, 32'd3, 32'd4, 1'b0, "madd");
    issue(4'd9, 32'd2, 32'd6, 1'b0, "msubu");
    issue(4'd8, 32'hFFFF_FFFE, 32'd5, 1'b0, "msub");

    for (int i = 0; i < 80; i++)
      issue(4'($urandom_range(0, 15)), pick(), pick(), ($urandom_range(0, 9) == 0), "rand");

    // Asynchronous reset in the middle of a multiply.
    wait_idle();
    push('0, '0, 2, "reset_mid");
    drive_start(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check32("async_rst_hi", hi, '0);
    check32("async_rst_lo", lo, '0);
    check32("async_rst_busy", 32'(md_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(4'd0, 32'd6, 32'd7, 1'b0, "post_reset");

    wait_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    finish_run();
  end

endmodule
